// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters with issue stall.
// Optional SCOREBOARD_BYPASS_EN lets a retiring last write unblock a reader.
module reg_scoreboard #(
  parameter int NREGS = 8,
  parameter int REG_W = 3,
  parameter int NSRC  = 2,
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_v,
  input  logic              issue_we,
  input  logic [REG_W-1:0]  issue_dst,
  input  logic [NSRC-1:0]   src_v,
  input  logic [NSRC*REG_W-1:0] src_reg,
  input  logic              wb_v,
  input  logic [REG_W-1:0]  wb_dst,
  input  logic              flush,
  output logic              stall,
  output logic [NREGS-1:0]  busy,
  output logic              err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt [NREGS];
  logic [REG_W-1:0] sreg;
  logic             hz;
  logic             src_haz;
  logic             full_haz;
  logic             inc;
  logic             dec;
  logic             uflow;
  logic [NREGS-1:0] up;
  logic [NREGS-1:0] dn;

  always_comb begin
    src_haz = 1'b0;
    sreg    = '0;
    hz      = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      sreg = src_reg[k*REG_W +: REG_W];
      hz   = src_v[k] && (cnt[sreg] != '0);
`ifdef SCOREBOARD_BYPASS_EN
      // last pending write retires now; datapath forwards it
      if (wb_v && (wb_dst == sreg) && (cnt[sreg] == CNT_ONE))
        hz = 1'b0;
`endif
      src_haz = src_haz | hz;
    end
  end

  assign full_haz = issue_we && (cnt[issue_dst] == CNT_MAX);
  assign stall    = issue_v && !flush && (src_haz || full_haz);
  assign inc      = issue_v && !flush && !stall && issue_we;
  assign dec      = wb_v && !flush && (cnt[wb_dst] != '0);
  assign uflow    = wb_v && !flush && (cnt[wb_dst] == '0);

  always_comb begin
    up   = '0;
    dn   = '0;
    busy = '0;
    for (int r = 0; r < NREGS; r++) begin
      up[r]   = inc && (issue_dst == REG_W'(r));
      dn[r]   = dec && (wb_dst == REG_W'(r));
      busy[r] = (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
      for (int r = 0; r < NREGS; r++)
        cnt[r] <= '0;
    end else begin
      if (uflow)
        err <= 1'b1;
      for (int r = 0; r < NREGS; r++) begin
        if (flush)
          cnt[r] <= '0;
        else if (up[r] && !dn[r])
          cnt[r] <= cnt[r] + CNT_ONE;
        else if (dn[r] && !up[r])
          cnt[r] <= cnt[r] - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: driver queues expectations,
// monitor pops and compares on the falling edge.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       issue_v = 1'b0;
  logic       issue_we = 1'b0;
  logic [2:0] issue_dst = '0;
  logic [1:0] src_v = '0;
  logic [5:0] src_reg = '0;
  logic       wb_v = 1'b0;
  logic [2:0] wb_dst = '0;
  logic       flush = 1'b0;
  logic       stall;
  logic [7:0] busy;
  logic       err;

  typedef struct {
    int         id;
    logic       st;
    logic [7:0] bz;
    logic       er;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   vid = 0;

`ifdef SCOREBOARD_BYPASS_EN
  localparam logic BYP_ST = 1'b0;
`else
  localparam logic BYP_ST = 1'b1;
`endif

  reg_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_v(issue_v), .issue_we(issue_we), .issue_dst(issue_dst),
    .src_v(src_v), .src_reg(src_reg),
    .wb_v(wb_v), .wb_dst(wb_dst), .flush(flush),
    .stall(stall), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic drv(
    input logic rs, input logic iv, input logic we, input logic [2:0] d,
    input logic [1:0] sv, input logic [2:0] s0, input logic [2:0] s1,
    input logic wv, input logic [2:0] wd, input logic fl,
    input logic est, input logic [7:0] ebz, input logic eer);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rs; issue_v = iv; issue_we = we; issue_dst = d;
    src_v = sv; src_reg = {s1, s0};
    wb_v = wv; wb_dst = wd; flush = fl;
    e.id = vid; e.st = est; e.bz = ebz; e.er = eer;
    q.push_back(e);
    vid++;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (stall !== e.st) begin
        n_err++;
        $display("FAIL v%0d stall got %b exp %b", e.id, stall, e.st);
      end
      if (busy !== e.bz) begin
        n_err++;
        $display("FAIL v%0d busy got %h exp %h", e.id, busy, e.bz);
      end
      if (err !== e.er) begin
        n_err++;
        $display("FAIL v%0d err got %b exp %b", e.id, err, e.er);
      end
    end
  end

  initial begin
    //  rs iv we d  sv     s0 s1 wv wd fl   st busy   er
    drv(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,   0, 8'h00, 0);
    drv(0, 1, 1, 3, 2'b00, 0, 0, 0, 0, 0,   0, 8'h00, 0);
    drv(0, 1, 0, 0, 2'b01, 3, 0, 0, 0, 0,   1, 8'h08, 0);
    drv(0, 1, 0, 0, 2'b01, 3, 0, 1, 3, 0,   BYP_ST, 8'h08, 0);
    drv(0, 1, 0, 0, 2'b01, 3, 0, 0, 0, 0,   0, 8'h00, 0);
    drv(0, 1, 1, 5, 2'b00, 0, 0, 0, 0, 0,   0, 8'h00, 0);
    drv(0, 1, 1, 5, 2'b00, 0, 0, 0, 0, 0,   0, 8'h20, 0);
    drv(0, 1, 1, 5, 2'b00, 0, 0, 0, 0, 0,   0, 8'h20, 0);
    drv(0, 1, 1, 5, 2'b00, 0, 0, 1, 5, 0,   1, 8'h20, 0);
    drv(0, 1, 1, 5, 2'b00, 0, 0, 0, 0, 0,   0, 8'h20, 0);
    drv(0, 1, 1, 2, 2'b00, 0, 0, 0, 0, 0,   0, 8'h20, 0);
    drv(0, 1, 1, 2, 2'b00, 0, 0, 1, 2, 0,   0, 8'h24, 0);
    drv(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,   0, 8'h24, 0);
    drv(0, 0, 0, 0, 2'b00, 0, 0, 1, 6, 0,   0, 8'h24, 0);
    drv(0, 1, 0, 0, 2'b10, 2, 5, 0, 0, 0,   1, 8'h24, 1);
    drv(0, 1, 1, 0, 2'b11, 0, 1, 0, 0, 0,   0, 8'h24, 1);
    drv(0, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0,   0, 8'h25, 1);
    drv(0, 1, 1, 3, 2'b00, 0, 0, 0, 0, 0,   0, 8'h27, 1);
    drv(0, 1, 1, 4, 2'b00, 0, 0, 0, 0, 0,   0, 8'h2F, 1);
    drv(0, 1, 1, 6, 2'b00, 0, 0, 0, 0, 0,   0, 8'h3F, 1);
    drv(0, 1, 1, 7, 2'b00, 0, 0, 0, 0, 0,   0, 8'h7F, 1);
    drv(0, 1, 1, 3, 2'b01, 3, 0, 1, 6, 1,   0, 8'hFF, 1);
    drv(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,   0, 8'h00, 1);
    drv(0, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0,   0, 8'h00, 1);
    drv(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,   0, 8'h02, 1);
    drv(1, 1, 0, 0, 2'b01, 1, 0, 0, 0, 0,   0, 8'h00, 0);
    drv(0, 1, 0, 0, 2'b01, 1, 0, 0, 0, 0,   0, 8'h00, 0);
    drv(0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 1,   0, 8'h00, 0);
    drv(0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 0,   0, 8'h00, 0);
    drv(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,   0, 8'h00, 1);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain left %0d exp 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
